xilly_lane_accum: RTL and testbench

XILLY_LANE_ACCUM -- requirements
Module: xilly_lane_accum

---
 rtl/xilly_lane_accum.sv | 175 +++++++++++++++++
 tb/tb_xilly_lane_accum.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xilly_lane_accum.sv
// Lane-wise block accumulator between a write FIFO and a read FIFO.
// Each word passes through pop -> accumulate -> push, so latency is three edges.
module xilly_lane_accum #(
  parameter int LANE_W    = 16,
  parameter int LANES     = 2,
  parameter int DEPTH     = 32,
  parameter int BLOCK_LEN = 512
) (
  input  logic                       bus_clk,
  input  logic                       quiesce,
  input  logic [1:0]                 mode,
  input  logic                       user_w_write_32_wren,
  input  logic [LANE_W*LANES-1:0]    user_w_write_32_data,
  output logic                       user_w_write_32_full,
  input  logic                       user_w_write_32_open,
  input  logic                       user_r_read_32_rden,
  output logic [LANE_W*LANES-1:0]    user_r_read_32_data,
  output logic                       user_r_read_32_empty,
  input  logic                       user_r_read_32_open,
  output logic                       block_done
);

  localparam int W  = LANE_W * LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW:0]   ROOM_LIM  = (CW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(BLOCK_LEN - 1);
  localparam logic [1:0]    MODE_WRAP = 2'b01;
  localparam logic [1:0]    MODE_SAT  = 2'b10;

  logic [W-1:0]  in_mem [DEPTH];
  logic [AW-1:0] in_wp, in_rp;
  logic [CW-1:0] in_cnt;
  logic [W-1:0]  out_mem [DEPTH];
  logic [AW-1:0] out_wp, out_rp;
  logic [CW-1:0] out_cnt;

  logic          wr_go, rd_go, pop, push;
  logic [CW:0]   committed;

  logic [IW-1:0] word_idx;
  logic [1:0]    mode_blk;
  logic          s1_valid, s1_first, s1_last;
  logic [1:0]    s1_mode;
  logic [W-1:0]  s1_data;
  logic          s2_valid, s2_last;
  logic [W-1:0]  s2_data;
  logic [W-1:0]  acc, acc_next, s2_next;
  logic [LANE_W-1:0] base, lane_res;
  logic [LANE_W:0]   sum;

  assign user_w_write_32_full  = (in_cnt == DEPTH_CNT);
  assign user_r_read_32_empty  = (out_cnt == '0);
  assign wr_go = user_w_write_32_wren & ~user_w_write_32_full & user_w_write_32_open;
  assign rd_go = user_r_read_32_rden & ~user_r_read_32_empty & user_r_read_32_open;
  assign push  = s2_valid;

  // Words already in the pipeline reserve output slots, so the read FIFO cannot overflow.
  assign committed = {1'b0, out_cnt} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
  assign pop = (in_cnt != '0) && (committed < ROOM_LIM)
               && user_w_write_32_open && user_r_read_32_open;

  assign block_done = s2_valid & s2_last;

  always_ff @(posedge bus_clk) begin
    if (wr_go) in_mem[in_wp] <= user_w_write_32_data;
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce || !user_w_write_32_open) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else begin
      if (wr_go) in_wp <= in_wp + 1'b1;
      if (pop)   in_rp <= in_rp + 1'b1;
      case ({wr_go, pop})
        2'b10:   in_cnt <= in_cnt + 1'b1;
        2'b01:   in_cnt <= in_cnt - 1'b1;
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      word_idx <= '0;
      mode_blk <= 2'b00;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 2'b00;
      s1_data  <= '0;
    end else begin
      if (!user_w_write_32_open)
        word_idx <= '0;
      else if (pop)
        word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
      s1_valid <= user_r_read_32_open & pop;
      if (pop) begin
        s1_data  <= in_mem[in_rp];
        s1_first <= (word_idx == '0);
        s1_last  <= (word_idx == LAST_IDX);
        s1_mode  <= (word_idx == '0) ? mode : mode_blk;
        if (word_idx == '0) mode_blk <= mode;
      end
    end
  end

  always_comb begin
    acc_next = acc;
    s2_next  = s1_data;
    base     = '0;
    sum      = '0;
    lane_res = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      base     = s1_first ? '0 : acc[k*LANE_W +: LANE_W];
      sum      = {1'b0, base} + {1'b0, s1_data[k*LANE_W +: LANE_W]};
      lane_res = (s1_mode == MODE_SAT && sum[LANE_W]) ? '1 : sum[LANE_W-1:0];
      if (s1_mode == MODE_WRAP || s1_mode == MODE_SAT) begin
        acc_next[k*LANE_W +: LANE_W] = lane_res;
        s2_next[k*LANE_W +: LANE_W]  = lane_res;
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce || !user_w_write_32_open)
      acc <= '0;
    else if (s1_valid && user_r_read_32_open)
      acc <= acc_next;
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce || !user_r_read_32_open) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_data  <= s2_next;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (push) out_mem[out_wp] <= s2_data;
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce || !user_r_read_32_open) begin
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (push)  out_wp <= out_wp + 1'b1;
      if (rd_go) out_rp <= out_rp + 1'b1;
      case ({push, rd_go})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce)
      user_r_read_32_data <= '0;
    else if (rd_go)
      user_r_read_32_data <= out_mem[out_rp];
  end

endmodule

// File: tb/tb_xilly_lane_accum.sv
// Randomized and directed bench for xilly_lane_accum against a queue-based block model.
module tb_xilly_lane_accum;

  localparam int LW = 16;
  localparam int NL = 2;
  localparam int DP = 8;
  localparam int BL = 4;
  localparam int W  = LW * NL;

  logic         clk = 1'b0;
  logic         quiesce = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         wren = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         full;
  logic         wopen = 1'b1;
  logic         rden = 1'b0;
  logic [W-1:0] rdata;
  logic         empty;
  logic         ropen = 1'b1;
  logic         block_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_rd = '0;
  int m_idx = 0;
  int m_mode = 0;
  int m_acc[NL];
  int done_cnt = 0;
  int rd_count = 0;

  always #5 clk = ~clk;

  xilly_lane_accum #(.LANE_W(LW), .LANES(NL), .DEPTH(DP), .BLOCK_LEN(BL)) dut (
    .bus_clk(clk),
    .quiesce(quiesce),
    .mode(mode),
    .user_w_write_32_wren(wren),
    .user_w_write_32_data(wdata),
    .user_w_write_32_full(full),
    .user_w_write_32_open(wopen),
    .user_r_read_32_rden(rden),
    .user_r_read_32_data(rdata),
    .user_r_read_32_empty(empty),
    .user_r_read_32_open(ropen),
    .block_done(block_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output word for an accepted input word, from the block rules.
  function automatic void model_push(input logic [W-1:0] w);
    logic [W-1:0] o;
    int lane, s, lim;
    lim = (1 << LW) - 1;
    if (m_idx == 0) begin
      m_mode = int'(mode);
      for (int k = 0; k < NL; k++) m_acc[k] = 0;
    end
    o = w;
    for (int k = 0; k < NL; k++) begin
      lane = int'(w[LW*k +: LW]);
      if (m_mode == 1) begin
        m_acc[k] = (m_acc[k] + lane) % (lim + 1);
        o[LW*k +: LW] = LW'(m_acc[k]);
      end else if (m_mode == 2) begin
        s = m_acc[k] + lane;
        m_acc[k] = (s > lim) ? lim : s;
        o[LW*k +: LW] = LW'(m_acc[k]);
      end
    end
    exp_q.push_back(o);
    m_idx = (m_idx + 1) % BL;
  endfunction

  task automatic tick(output bit w_acc);
    bit r_acc;
    w_acc = wren && !full && wopen && !quiesce;
    r_acc = rden && !empty && ropen && !quiesce;
    if (r_acc) begin
      check("rd_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) exp_rd = exp_q.pop_front();
      rd_count++;
    end
    if (w_acc) model_push(wdata);
    @(posedge clk);
    @(negedge clk);
    if (quiesce || (!wopen && !ropen)) begin
      exp_q.delete();
      m_idx = 0;
    end
    if (quiesce) exp_rd = '0;
    check("rd_data", 64'(rdata), 64'(exp_rd));
    if (r_acc) got_q.push_back(rdata);
    if (block_done) done_cnt++;
  endtask

  task automatic step();
    bit d;
    tick(d);
  endtask

  task automatic do_reset();
    quiesce = 1'b1;
    wren = 1'b0;
    rden = 1'b0;
    step();
    step();
    quiesce = 1'b0;
    done_cnt = 0;
    rd_count = 0;
    got_q.delete();
  endtask

  task automatic write_n(input int n, input logic [W-1:0] w);
    bit a;
    int sent = 0;
    int budget = 0;
    wren = 1'b1;
    wdata = w;
    while (sent < n && budget < 200) begin
      tick(a);
      if (a) sent++;
      budget++;
    end
    check("write_n_accept", 64'(sent), 64'(n));
    wren = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    wren = 1'b0;
    rden = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (4) step();
    check("empty_after_drain", 64'(empty), 64'd1);
    rden = 1'b0;
  endtask

  task automatic check_table(input string tag, input logic [W-1:0] tbl[$]);
    check({tag, "_count"}, 64'(got_q.size()), 64'(tbl.size()));
    for (int j = 0; j < tbl.size() && j < got_q.size(); j++)
      check(tag, 64'(got_q[j]), 64'(tbl[j]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int i, cyc, n;
    logic [W-1:0] tbl[$];

    @(negedge clk);
    do_reset();
    check("reset_full", 64'(full), 64'd0);
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_done", 64'(block_done), 64'd0);

    // Latency: write at edge t, empty drops only after edge t+3.
    mode = 2'b00;
    wren = 1'b1;
    wdata = 32'h1234_5678;
    step();
    wren = 1'b0;
    step();
    check("lat_t1", 64'(empty), 64'd1);
    step();
    check("lat_t2", 64'(empty), 64'd1);
    step();
    check("lat_t3", 64'(empty), 64'd0);
    drain();

    // Long pass-through stream with the reader draining.
    do_reset();
    mode = 2'b00;
    rden = 1'b1;
    wren = 1'b1;
    i = 0;
    cyc = 0;
    while (i < 1030 && cyc < 1300) begin
      wdata = {LW'(2 * i + 1), LW'(2 * i)};
      tick(a);
      if (a) i++;
      cyc++;
    end
    check("stream_accepted", 64'(i), 64'd1030);
    check("stream_rate", 64'(cyc <= 1032), 64'd1);
    drain();
    check("stream_reads", 64'(rd_count), 64'd1030);

    // Wrapping sum over two blocks.
    do_reset();
    mode = 2'b01;
    rden = 1'b1;
    write_n(8, 32'h4000_4000);
    drain();
    tbl = '{32'h4000_4000, 32'h8000_8000, 32'hC000_C000, 32'h0000_0000,
            32'h4000_4000, 32'h8000_8000, 32'hC000_C000, 32'h0000_0000};
    check_table("wrap_tbl", tbl);
    check("wrap_done", 64'(done_cnt), 64'd2);

    // Saturating sum.
    do_reset();
    mode = 2'b10;
    rden = 1'b1;
    write_n(4, 32'hF000_F000);
    drain();
    tbl = '{32'hF000_F000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    check_table("sat_tbl", tbl);
    check("sat_done", 64'(done_cnt), 64'd1);

    // Reader stalled: both FIFOs fill, excess writes dropped.
    do_reset();
    mode = 2'b00;
    wren = 1'b1;
    n = 0;
    for (int k = 0; k < 2 * DP + 8; k++) begin
      wdata = $urandom;
      tick(a);
      if (a) n++;
    end
    wren = 1'b0;
    check("full_flag", 64'(full), 64'd1);
    check("full_accepted", 64'(n), 64'(2 * DP));
    drain();
    check("full_reads", 64'(rd_count), 64'(2 * DP));

    // Quiesce mid-block with both FIFOs holding data.
    do_reset();
    mode = 2'b01;
    wren = 1'b1;
    for (int k = 0; k < DP + 3; k++) begin
      wdata = $urandom;
      step();
    end
    wren = 1'b0;
    quiesce = 1'b1;
    step();
    quiesce = 1'b0;
    check("q_empty", 64'(empty), 64'd1);
    check("q_full", 64'(full), 64'd0);
    got_q.delete();
    done_cnt = 0;
    rden = 1'b1;
    write_n(4, 32'h0003_0001);
    drain();
    tbl = '{32'h0003_0001, 32'h0006_0002, 32'h0009_0003, 32'h000C_0004};
    check_table("q_tbl", tbl);
    check("q_done", 64'(done_cnt), 64'd1);

    // Mode change mid-block applies from the next block.
    do_reset();
    mode = 2'b01;
    rden = 1'b1;
    write_n(2, 32'h6000_6000);
    repeat (4) step();
    mode = 2'b10;
    write_n(2, 32'h6000_6000);
    write_n(4, 32'hC000_C000);
    drain();
    tbl = '{32'h6000_6000, 32'hC000_C000, 32'h2000_2000, 32'h8000_8000,
            32'hC000_C000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    check_table("mchg_tbl", tbl);

    // Closing both streams discards data and restarts the block.
    do_reset();
    mode = 2'b01;
    write_n(2, 32'h0001_0001);
    repeat (4) step();
    wopen = 1'b0;
    ropen = 1'b0;
    wren = 1'b1;
    wdata = 32'hDEAD_BEEF;
    rden = 1'b1;
    step();
    step();
    check("closed_empty", 64'(empty), 64'd1);
    check("closed_full", 64'(full), 64'd0);
    wren = 1'b0;
    rden = 1'b0;
    wopen = 1'b1;
    ropen = 1'b1;
    step();
    got_q.delete();
    write_n(4, 32'h0001_0001);
    drain();
    tbl = '{32'h0001_0001, 32'h0002_0002, 32'h0003_0003, 32'h0004_0004};
    check_table("open_tbl", tbl);

    // Random traffic in every mode with occasional quiesce.
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      mode = 2'($urandom_range(0, 3));
      for (int c = 0; c < 300; c++) begin
        wren = ($urandom_range(0, 9) < 7);
        rden = ($urandom_range(0, 9) < 6);
        wdata = ($urandom_range(0, 3) == 0) ? 32'hFFF0_FFF0 | W'($urandom_range(0, 15))
                                            : W'($urandom);
        quiesce = ($urandom_range(0, 199) == 0);
        step();
      end
      quiesce = 1'b0;
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
